usb_tx_pkt_feeder: RTL and testbench

Packet-level transmit feeder sitting directly upstream of `usb_top`. It buffers whole USB packets (PID + payload bytes) written by the host side and drives the SIE transmit handshake, one packet at a time: `SYN_GEN_LD`, `CRC_16`, `TX_LOAD`/`TX_DATA`, `TX_LAST_BYTE`. It throttles on `TX_READY_LD` and waits for `T_lastbit` before starting the next packet.

---
 rtl/usb_tx_pkg.sv | 38 +++
 rtl/usb_tx_byte_fifo.sv | 70 +++++++
 rtl/usb_tx_pkt_feeder.sv | 194 +++++++++++++++++++
 tb/tb_usb_tx_pkt_feeder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet feeder.
// PID constants, the FSM state encoding and the FIFO entry layout live here.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_HOLD,
        ST_END,
        ST_DRAIN,
        ST_GAP,
        ST_DROP
    } tx_state_t;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    // DATA0/DATA1/DATA2/MDATA all end in 2'b11 and carry a CRC16.
    function automatic logic pid_is_data(input logic [7:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

    function automatic logic pid_check_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_tx_byte_fifo.sv
// 9-bit {last, byte} synchronous FIFO with registered full/empty flags
// and a single-cycle synchronous flush.
module usb_tx_byte_fifo
    import usb_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  fifo_entry_t wr_entry,
    input  logic        rd_en,
    input  logic        flush,
    output fifo_entry_t head_c,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          do_wr;
    logic          do_rd;

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        count_nx = count;
        if (flush) begin
            count_nx = '0;
        end else if (do_wr && !do_rd) begin
            count_nx = count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_nx = count - CW'(1);
        end
    end

    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + AW'(1);
                if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nx;
            full  <= (count_nx == CW'(DEPTH));
            empty <= (count_nx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/usb_tx_pkt_feeder.sv
// Buffers whole USB packets and drives the SIE transmit handshake one packet at a time.
// Optional PID complement check and drop path: define USB_TX_PID_CHK_EN.
module usb_tx_pkt_feeder
    import usb_tx_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    output logic       wr_full,
    output logic       ovf_err,
    output logic       pkt_pending,
    output logic       busy,
    output logic       SYN_GEN_LD,
    output logic       CRC_16,
    output logic       TX_LOAD,
    output logic [7:0] TX_DATA,
    output logic       TX_LAST_BYTE,
    input  logic       TX_READY_LD,
    input  logic       T_lastbit,
    output logic       pid_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    tx_state_t     state;
    fifo_entry_t   head_c;
    fifo_entry_t   wr_entry_c;
    logic          fifo_empty;
    logic          push_c;
    logic          pop_c;
    logic          flush_c;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] pkt_cnt_nx;
    logic [GW-1:0] gap_cnt;
    logic          end_wait;

    assign wr_entry_c = '{last: wr_last, data: wr_data};
    assign push_c     = wr_en && !wr_full;
    // A full FIFO with no complete packet can never drain: discard it.
    assign flush_c    = wr_full && (pkt_cnt == '0);

    usb_tx_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (gclk),
        .rst_n   (reset_l),
        .wr_en   (wr_en),
        .wr_entry(wr_entry_c),
        .rd_en   (pop_c),
        .flush   (flush_c),
        .head_c  (head_c),
        .full    (wr_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        pop_c = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_LOAD && TX_READY_LD) pop_c = 1'b1;
`ifdef USB_TX_PID_CHK_EN
            if (state == ST_DROP) pop_c = 1'b1;
`endif
        end
    end

    always_comb begin
        pkt_cnt_nx = pkt_cnt;
        if ((push_c && wr_last) && !(pop_c && head_c.last)) begin
            pkt_cnt_nx = pkt_cnt + CW'(1);
        end else if (!(push_c && wr_last) && (pop_c && head_c.last)) begin
            pkt_cnt_nx = pkt_cnt - CW'(1);
        end
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            pkt_cnt     <= '0;
            pkt_pending <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            pkt_cnt     <= pkt_cnt_nx;
            pkt_pending <= (pkt_cnt_nx != '0);
            ovf_err     <= (wr_en && wr_full) || flush_c;
        end
    end

`ifdef USB_TX_PID_CHK_EN
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            pid_err <= 1'b0;
        end else begin
            pid_err <= (state == ST_DROP) && pop_c && head_c.last;
        end
    end
`else
    assign pid_err = 1'b0;
`endif

    // Transmit sequencer; strobes default low and pulse for one cycle.
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            SYN_GEN_LD   <= 1'b0;
            CRC_16       <= 1'b0;
            TX_LOAD      <= 1'b0;
            TX_DATA      <= 8'h00;
            TX_LAST_BYTE <= 1'b0;
            gap_cnt      <= '0;
            end_wait     <= 1'b0;
        end else begin
            SYN_GEN_LD   <= 1'b0;
            TX_LOAD      <= 1'b0;
            TX_LAST_BYTE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pkt_pending) begin
                        busy   <= 1'b1;
                        state  <= ST_SYNC;
                        CRC_16 <= pid_is_data(head_c.data);
`ifdef USB_TX_PID_CHK_EN
                        if (!pid_check_ok(head_c.data)) begin
                            state  <= ST_DROP;
                            CRC_16 <= 1'b0;
                        end
`endif
                    end
                end
                ST_SYNC: begin
                    SYN_GEN_LD <= 1'b1;
                    state      <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (pop_c) begin
                        TX_LOAD <= 1'b1;
                        TX_DATA <= head_c.data;
                        if (head_c.last) begin
                            state    <= ST_END;
                            end_wait <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    state <= ST_LOAD;
                end
                ST_END: begin
                    // Dead cycle first so the end marker never crowds the final load.
                    if (end_wait) begin
                        end_wait <= 1'b0;
                    end else if (TX_READY_LD) begin
                        TX_LAST_BYTE <= 1'b1;
                        state        <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (T_lastbit) begin
                        gap_cnt <= GW'(GAP_CYCLES);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        CRC_16 <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
`ifdef USB_TX_PID_CHK_EN
                ST_DROP: begin
                    if (pop_c && head_c.last) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_pkt_feeder.sv
// Scoreboard bench for usb_tx_pkt_feeder: stimulus pushes expected SIE events,
// a negedge monitor pops and compares them as strobes appear.
module tb_usb_tx_pkt_feeder;
    import usb_tx_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 4;

    localparam logic [1:0] EV_SYN  = 2'd0;
    localparam logic [1:0] EV_LOAD = 2'd1;
    localparam logic [1:0] EV_LAST = 2'd2;
    localparam logic [1:0] EV_PERR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       crc;
    } ev_t;

    logic       gclk = 1'b0;
    logic       reset_l = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       TX_READY_LD = 1'b0;
    logic       T_lastbit = 1'b0;
    logic       wr_full, ovf_err, pkt_pending, busy, SYN_GEN_LD, CRC_16;
    logic       TX_LOAD, TX_LAST_BYTE, pid_err;
    logic [7:0] TX_DATA;

    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  last_load_cyc = -100;
    int  load_cnt = 0;
    int  last_cnt = 0;
    int  syn_cnt = 0;
    int  rdy_mode = 0;
    logic ready_at_edge = 1'b0;
    ev_t exp_q[$];

    usb_tx_pkt_feeder #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
    ) dut (
        .gclk        (gclk),
        .reset_l     (reset_l),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_full     (wr_full),
        .ovf_err     (ovf_err),
        .pkt_pending (pkt_pending),
        .busy        (busy),
        .SYN_GEN_LD  (SYN_GEN_LD),
        .CRC_16      (CRC_16),
        .TX_LOAD     (TX_LOAD),
        .TX_DATA     (TX_DATA),
        .TX_LAST_BYTE(TX_LAST_BYTE),
        .TX_READY_LD (TX_READY_LD),
        .T_lastbit   (T_lastbit),
        .pid_err     (pid_err)
    );

    always #5 gclk = ~gclk;

    always @(posedge gclk) begin
        cyc           <= cyc + 1;
        ready_at_edge <= TX_READY_LD;
    end

    // Ready: 0 = never, 1 = always, 2 = one cycle in every eight.
    always @(negedge gclk) begin
        TX_READY_LD = (rdy_mode == 1) ? 1'b1 :
                      (rdy_mode == 2) ? ((cyc % 8) == 0) : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data, input logic crc);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.crc  = crc;
        exp_q.push_back(e);
    endtask

    task automatic got(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected no event (t=%0t)",
                     kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || (kind == EV_LOAD && e.data !== data) || e.crc !== CRC_16) begin
                n_fail++;
                $display("FAIL sie_event: got kind %0d data %0h crc %0b, expected kind %0d data %0h crc %0b (t=%0t)",
                         kind, data, CRC_16, e.kind, e.data, e.crc, $time);
            end
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge gclk) begin
        if (reset_l) begin
            if (SYN_GEN_LD) begin
                got(EV_SYN, 8'h00);
                syn_cnt++;
            end
            if (TX_LOAD) begin
                got(EV_LOAD, TX_DATA);
                chk("load_needs_ready", 32'(ready_at_edge), 32'd1);
                chk("load_spacing_ge2", 32'((cyc - last_load_cyc) >= 2), 32'd1);
                last_load_cyc = cyc;
                load_cnt++;
            end
            if (TX_LAST_BYTE) begin
                got(EV_LAST, 8'h00);
                chk("last_after_load_ge2", 32'((cyc - last_load_cyc) >= 2), 32'd1);
                chk("last_not_with_load", 32'(TX_LOAD), 32'd0);
                last_cnt++;
            end
            if (pid_err) got(EV_PERR, 8'h00);
        end
    end

    task automatic wr(input logic [7:0] d, input logic l);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        @(negedge gclk);
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic wait_last(input int target, input string name);
        int n = 0;
        while (last_cnt < target && n < 400) begin
            @(negedge gclk);
            #1;
            n++;
        end
        chk(name, 32'(last_cnt), 32'(target));
    endtask

    task automatic finish_pkt(input string name);
        int n = 0;
        repeat (3) @(negedge gclk);
        T_lastbit = 1'b1;
        @(negedge gclk);
        T_lastbit = 1'b0;
        while (busy && n < 64) begin
            @(negedge gclk);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge gclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_full", 32'(wr_full), 32'd0);
        chk("rst_pkt_pending", 32'(pkt_pending), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'h00);
        chk("rst_strobes", 32'({SYN_GEN_LD, TX_LOAD, TX_LAST_BYTE, ovf_err, pid_err, CRC_16}), 32'd0);
        reset_l = 1'b1;
        repeat (2) @(negedge gclk);

        // DATA0 packet, ready held high
        rdy_mode = 1;
        repeat (2) @(negedge gclk);
        expect_ev(EV_SYN, 8'h00, 1'b1);
        expect_ev(EV_LOAD, 8'hC3, 1'b1);
        expect_ev(EV_LOAD, 8'h3F, 1'b1);
        expect_ev(EV_LOAD, 8'hB4, 1'b1);
        expect_ev(EV_LOAD, 8'h85, 1'b1);
        expect_ev(EV_LAST, 8'h00, 1'b1);
        wr(8'hC3, 1'b0);
        wr(8'h3F, 1'b0);
        wr(8'hB4, 1'b0);
        wr(8'h85, 1'b1);
        chk("t1_pkt_pending", 32'(pkt_pending), 32'd1);
        @(negedge gclk);
        chk("t1_syn_not_yet", 32'(SYN_GEN_LD), 32'd0);
        @(negedge gclk);
        chk("t1_syn_latency", 32'(SYN_GEN_LD), 32'd1);
        wait_last(1, "t1_last_seen");
        chk("t1_load_count", 32'(load_cnt), 32'd4);
        repeat (10) @(negedge gclk);
        T_lastbit = 1'b1;
        @(negedge gclk);
        T_lastbit = 1'b0;
        repeat (GAP) @(negedge gclk);
        chk("t1_busy_in_gap", 32'(busy), 32'd1);
        @(negedge gclk);
        chk("t1_busy_after_gap", 32'(busy), 32'd0);
        chk("t1_crc_cleared", 32'(CRC_16), 32'd0);

        // Token then DATA1, ready one cycle in eight
        rdy_mode = 2;
        expect_ev(EV_SYN, 8'h00, 1'b0);
        expect_ev(EV_LOAD, 8'h69, 1'b0);
        expect_ev(EV_LOAD, 8'h00, 1'b0);
        expect_ev(EV_LOAD, 8'h10, 1'b0);
        expect_ev(EV_LAST, 8'h00, 1'b0);
        expect_ev(EV_SYN, 8'h00, 1'b1);
        expect_ev(EV_LOAD, 8'h4B, 1'b1);
        expect_ev(EV_LOAD, 8'hAA, 1'b1);
        expect_ev(EV_LOAD, 8'h55, 1'b1);
        expect_ev(EV_LAST, 8'h00, 1'b1);
        wr(8'h69, 1'b0);
        wr(8'h00, 1'b0);
        wr(8'h10, 1'b1);
        wr(8'h4B, 1'b0);
        wr(8'hAA, 1'b0);
        wr(8'h55, 1'b1);
        wait_last(2, "t2_first_last");
        base = syn_cnt;
        repeat (12) @(negedge gclk);
        chk("t2_no_syn_before_lastbit", 32'(syn_cnt), 32'(base));
        chk("t2_busy_in_drain", 32'(busy), 32'd1);
        T_lastbit = 1'b1;
        @(negedge gclk);
        T_lastbit = 1'b0;
        repeat (GAP + 2) @(negedge gclk);
        chk("t2_syn_not_early", 32'(SYN_GEN_LD), 32'd0);
        @(negedge gclk);
        chk("t2_syn_after_gap", 32'(SYN_GEN_LD), 32'd1);
        wait_last(3, "t2_second_last");
        finish_pkt("t2_idle");

        // Over-long packet: drop plus flush
        rdy_mode = 0;
        for (int i = 0; i < int'(DEPTH); i++) wr(8'h10 + 8'(i), 1'b0);
        chk("t3_full", 32'(wr_full), 32'd1);
        chk("t3_no_pending", 32'(pkt_pending), 32'd0);
        wr(8'hEE, 1'b0);
        chk("t3_ovf_pulse", 32'(ovf_err), 32'd1);
        chk("t3_flushed", 32'(wr_full), 32'd0);
        @(negedge gclk);
        chk("t3_ovf_single", 32'(ovf_err), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Reset in the middle of a 5-byte packet
        rdy_mode = 1;
        repeat (2) @(negedge gclk);
        base = load_cnt;
        expect_ev(EV_SYN, 8'h00, 1'b1);
        expect_ev(EV_LOAD, 8'hC3, 1'b1);
        expect_ev(EV_LOAD, 8'h01, 1'b1);
        wr(8'hC3, 1'b0);
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b0);
        wr(8'h04, 1'b1);
        for (int n = 0; n < 100 && load_cnt < base + 2; n++) begin
            @(negedge gclk);
            #1;
        end
        chk("t4_two_loads", 32'(load_cnt), 32'(base + 2));
        base = last_cnt;
        reset_l = 1'b0;
        #1;
        chk("t4_async_load_drop", 32'(TX_LOAD), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_pending", 32'(pkt_pending), 32'd0);
        chk("t4_tx_data", 32'(TX_DATA), 32'h00);
        chk("t4_crc", 32'(CRC_16), 32'd0);
        chk("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge gclk);
        reset_l = 1'b1;
        repeat (20) @(negedge gclk);
        chk("t4_no_last", 32'(last_cnt), 32'(base));
        // single-byte packet proves the FIFO was emptied
        expect_ev(EV_SYN, 8'h00, 1'b0);
        expect_ev(EV_LOAD, PID_ACK, 1'b0);
        expect_ev(EV_LAST, 8'h00, 1'b0);
        wr(PID_ACK, 1'b1);
        wait_last(base + 1, "t4_single_byte_last");
        finish_pkt("t4_idle");

`ifdef USB_TX_PID_CHK_EN
        // Corrupt PID is dropped, next packet goes out
        base = last_cnt;
        expect_ev(EV_PERR, 8'h00, 1'b0);
        expect_ev(EV_SYN, 8'h00, 1'b0);
        expect_ev(EV_LOAD, 8'hD2, 1'b0);
        expect_ev(EV_LAST, 8'h00, 1'b0);
        wr(8'hA6, 1'b0);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b1);
        wr(8'hD2, 1'b1);
        wait_last(base + 1, "t5_last");
        finish_pkt("t5_idle");
`endif

        repeat (5) @(negedge gclk);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
